// File: rtl/l1d_pkg.sv
// Shared types and constants for the L1 data-cache refill controller.
// State encoding is 3 bits; size codes are one-hot byte widths.
package l1d_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LINE = 3'd1,
        ST_SRD  = 3'd2,
        ST_SWR  = 3'd3,
        ST_HOLD = 3'd4
    } state_t;

    localparam logic [3:0] SIZE_B1 = 4'b0001;
    localparam logic [3:0] SIZE_B2 = 4'b0010;
    localparam logic [3:0] SIZE_B4 = 4'b0100;
    localparam logic [3:0] SIZE_B8 = 4'b1000;

    localparam int BEAT_BYTES = 8;

endpackage

// File: rtl/l1d_bus_watchdog.sv
// Per-beat bus watchdog: a down-counter reloaded whenever the bus is idle or a
// beat resolves, raising expire on the TIMEOUT-th consecutive unanswered cycle.
module l1d_bus_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic expire
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] LOAD = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (!enable || clear) begin
            cnt <= LOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // TIMEOUT of zero disables the watchdog entirely.
    assign expire = (TIMEOUT != 0) && enable && !clear && (cnt == '0);

endmodule

// File: rtl/l1d_refill_ctrl.sv
// L1 data-cache refill / single-access controller driving a req/ack bus master.
// One transaction in flight; all outputs are registered.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for an L1 request level
// LINE    | line refill, sequential 64-bit beats from offset 0
// SRD     | single uncached read
// SWR     | single write-through
// HOLD    | one-cycle gap after completion/error, requests ignored
module l1d_refill_ctrl
    import l1d_pkg::*;
#(
    parameter int LINE_BYTES = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read_line_req,
    input  logic        read_req,
    input  logic        write_through_req,
    input  logic [63:0] pa,
    input  logic [3:0]  L1_size,
    input  logic [63:0] wt_data,
    output logic [63:0] line_data,
    output logic [10:0] addr_count,
    output logic        line_write,
    output logic        cache_entry_refill,
    output logic        trans_rdy,
    output logic        bus_error,
    output logic        bus_req,
    output logic        bus_we,
    output logic [63:0] bus_addr,
    output logic [3:0]  bus_size,
    output logic [63:0] bus_wdata,
    input  logic [63:0] bus_rdata,
    input  logic        bus_ack,
    input  logic        bus_err
);

    localparam int          OFFW     = $clog2(LINE_BYTES);
    localparam logic [10:0] LAST_OFF = 11'(LINE_BYTES - BEAT_BYTES);

    state_t      state, state_d;
    logic [63:0] line_data_d, bus_addr_d, bus_wdata_d;
    logic [10:0] addr_count_d, cur_off;
    logic [3:0]  bus_size_d;
    logic        bus_req_d, bus_we_d;
    logic        line_write_d, refill_d, trans_rdy_d, bus_error_d;
    logic        wd_expire, fail;

    l1d_bus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .enable (bus_req),
        .clear  (bus_ack || bus_err),
        .expire (wd_expire)
    );

    // bus_addr low bits track the beat being requested; addr_count reports the
    // beat just written so it lines up with the registered line_write pulse.
    assign cur_off = 11'(bus_addr[OFFW-1:0]);
    assign fail    = bus_err || wd_expire;

    always_comb begin
        state_d      = state;
        bus_req_d    = bus_req;
        bus_we_d     = bus_we;
        bus_addr_d   = bus_addr;
        bus_size_d   = bus_size;
        bus_wdata_d  = bus_wdata;
        line_data_d  = line_data;
        addr_count_d = addr_count;
        line_write_d = 1'b0;
        refill_d     = 1'b0;
        trans_rdy_d  = 1'b0;
        bus_error_d  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (read_line_req) begin
                    state_d      = ST_LINE;
                    bus_req_d    = 1'b1;
                    bus_we_d     = 1'b0;
                    bus_size_d   = SIZE_B8;
                    bus_addr_d   = {pa[63:OFFW], {OFFW{1'b0}}};
                    addr_count_d = '0;
                end else if (read_req) begin
                    state_d    = ST_SRD;
                    bus_req_d  = 1'b1;
                    bus_we_d   = 1'b0;
                    bus_size_d = L1_size;
                    bus_addr_d = pa;
                end else if (write_through_req) begin
                    state_d     = ST_SWR;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b1;
                    bus_size_d  = L1_size;
                    bus_addr_d  = pa;
                    bus_wdata_d = wt_data;
                end
            end
            ST_LINE, ST_SRD, ST_SWR: begin
                if (fail) begin
                    bus_error_d  = 1'b1;
                    bus_req_d    = 1'b0;
                    addr_count_d = '0;
                    state_d      = ST_HOLD;
                end else if (bus_ack) begin
                    if (state == ST_LINE) begin
                        line_data_d  = bus_rdata;
                        line_write_d = 1'b1;
                        addr_count_d = cur_off;
                        if (cur_off == LAST_OFF) begin
                            refill_d    = 1'b1;
                            trans_rdy_d = 1'b1;
                            bus_req_d   = 1'b0;
                            state_d     = ST_HOLD;
                        end else begin
                            bus_addr_d = bus_addr + 64'(BEAT_BYTES);
                        end
                    end else begin
                        if (state == ST_SRD) line_data_d = bus_rdata;
                        trans_rdy_d = 1'b1;
                        bus_req_d   = 1'b0;
                        state_d     = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                state_d      = ST_IDLE;
                addr_count_d = '0;
            end
            default: begin
                state_d   = ST_IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state              <= ST_IDLE;
            bus_req            <= 1'b0;
            bus_we             <= 1'b0;
            bus_addr           <= '0;
            bus_size           <= '0;
            bus_wdata          <= '0;
            line_data          <= '0;
            addr_count         <= '0;
            line_write         <= 1'b0;
            cache_entry_refill <= 1'b0;
            trans_rdy          <= 1'b0;
            bus_error          <= 1'b0;
        end else begin
            state              <= state_d;
            bus_req            <= bus_req_d;
            bus_we             <= bus_we_d;
            bus_addr           <= bus_addr_d;
            bus_size           <= bus_size_d;
            bus_wdata          <= bus_wdata_d;
            line_data          <= line_data_d;
            addr_count         <= addr_count_d;
            line_write         <= line_write_d;
            cache_entry_refill <= refill_d;
            trans_rdy          <= trans_rdy_d;
            bus_error          <= bus_error_d;
        end
    end

endmodule

// File: tb/tb_l1d_refill_ctrl.sv
// Directed bench for l1d_refill_ctrl: refill, single read, write-through,
// bus error mid-refill, watchdog expiry and reset mid-transaction.
module tb_l1d_refill_ctrl;

    logic        clk;
    logic        rst;
    logic        read_line_req, read_req, write_through_req;
    logic [63:0] pa, wt_data, bus_rdata;
    logic [3:0]  L1_size;
    logic [63:0] line_data, bus_addr, bus_wdata;
    logic [10:0] addr_count;
    logic        line_write, cache_entry_refill, trans_rdy, bus_error;
    logic        bus_req, bus_we, bus_ack, bus_err;
    logic [3:0]  bus_size;

    int checks = 0;
    int errors = 0;

    l1d_refill_ctrl #(.LINE_BYTES(32), .TIMEOUT(4)) dut (
        .clk                (clk),
        .rst                (rst),
        .read_line_req      (read_line_req),
        .read_req           (read_req),
        .write_through_req  (write_through_req),
        .pa                 (pa),
        .L1_size            (L1_size),
        .wt_data            (wt_data),
        .line_data          (line_data),
        .addr_count         (addr_count),
        .line_write         (line_write),
        .cache_entry_refill (cache_entry_refill),
        .trans_rdy          (trans_rdy),
        .bus_error          (bus_error),
        .bus_req            (bus_req),
        .bus_we             (bus_we),
        .bus_addr           (bus_addr),
        .bus_size           (bus_size),
        .bus_wdata          (bus_wdata),
        .bus_rdata          (bus_rdata),
        .bus_ack            (bus_ack),
        .bus_err            (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        rst = 1'b0;
        read_line_req = 1'b0; read_req = 1'b0; write_through_req = 1'b0;
        pa = '0; wt_data = '0; L1_size = 4'b0000;
        bus_rdata = '0; bus_ack = 1'b0; bus_err = 1'b0;
        tick; tick;
        chk("rst_req",   64'(bus_req),    64'd0);
        chk("rst_addr",  bus_addr,        64'd0);
        chk("rst_cnt",   64'(addr_count), 64'd0);
        chk("rst_trdy",  64'(trans_rdy),  64'd0);
        chk("rst_ldata", line_data,       64'd0);
        rst = 1'b1;
        tick;

        // line refill, ack every cycle
        read_line_req = 1'b1; pa = 64'h1234_5678;
        tick;
        chk("rf_req",  64'(bus_req),  64'd1);
        chk("rf_addr0", bus_addr,     64'h1234_5660);
        chk("rf_size", 64'(bus_size), 64'h8);
        chk("rf_we",   64'(bus_we),   64'd0);
        read_line_req = 1'b0; bus_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus_rdata = 64'hC0DE_0000_0000_0000 + 64'(i);
            tick;
            chk("rf_lw",   64'(line_write), 64'd1);
            chk("rf_off",  64'(addr_count), 64'(8 * i));
            chk("rf_data", line_data, 64'hC0DE_0000_0000_0000 + 64'(i));
            if (i < 3) begin
                chk("rf_addr",   bus_addr, 64'h1234_5660 + 64'(8 * (i + 1)));
                chk("rf_early",  64'(cache_entry_refill), 64'd0);
                chk("rf_etrdy",  64'(trans_rdy), 64'd0);
            end else begin
                chk("rf_refill", 64'(cache_entry_refill), 64'd1);
                chk("rf_trdy",   64'(trans_rdy), 64'd1);
                chk("rf_reqlo",  64'(bus_req), 64'd0);
            end
        end

        // single read, requested while the controller sits in HOLD
        bus_ack = 1'b0; read_req = 1'b1; pa = 64'h1003; L1_size = 4'b0001;
        tick;
        chk("hold_ign",  64'(bus_req),    64'd0);
        chk("hold_cnt",  64'(addr_count), 64'd0);
        chk("hold_lw",   64'(line_write), 64'd0);
        tick;
        chk("srd_req",  64'(bus_req),  64'd1);
        chk("srd_addr", bus_addr,      64'h1003);
        chk("srd_size", 64'(bus_size), 64'h1);
        pa = 64'hFFFF_0000; L1_size = 4'b1000; read_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick;
            chk("srd_wreq",  64'(bus_req),  64'd1);
            chk("srd_waddr", bus_addr,      64'h1003);
            chk("srd_wtrdy", 64'(trans_rdy), 64'd0);
        end
        bus_ack = 1'b1; bus_rdata = 64'hAB;
        tick;
        chk("srd_trdy",  64'(trans_rdy),  64'd1);
        chk("srd_data",  line_data,       64'hAB);
        chk("srd_nolw",  64'(line_write), 64'd0);
        chk("srd_reqlo", 64'(bus_req),    64'd0);
        bus_ack = 1'b0;
        tick;
        chk("srd_pulse", 64'(trans_rdy), 64'd0);

        // write-through with two wait cycles
        write_through_req = 1'b1; pa = 64'h2000; L1_size = 4'b0100; wt_data = 64'hDEAD_BEEF;
        tick;
        chk("swr_req",   64'(bus_req),  64'd1);
        chk("swr_we",    64'(bus_we),   64'd1);
        chk("swr_size",  64'(bus_size), 64'h4);
        chk("swr_addr",  bus_addr,      64'h2000);
        chk("swr_wdata", bus_wdata,     64'hDEAD_BEEF);
        write_through_req = 1'b0; wt_data = '0;
        for (int k = 0; k < 2; k++) begin
            tick;
            chk("swr_hold", bus_wdata, 64'hDEAD_BEEF);
            chk("swr_wreq", 64'(bus_req), 64'd1);
        end
        bus_ack = 1'b1;
        tick;
        chk("swr_trdy",   64'(trans_rdy),          64'd1);
        chk("swr_nolw",   64'(line_write),         64'd0);
        chk("swr_norf",   64'(cache_entry_refill), 64'd0);
        bus_ack = 1'b0;
        tick;
        chk("swr_pulse", 64'(trans_rdy), 64'd0);
        tick;

        // refill with bus_err (and ack) on the third beat
        read_line_req = 1'b1; pa = 64'h4000_0048;
        tick;
        chk("re_addr", bus_addr, 64'h4000_0040);
        read_line_req = 1'b0; bus_ack = 1'b1; bus_rdata = 64'h11;
        tick;
        chk("re_lw0",  64'(line_write), 64'd1);
        chk("re_off0", 64'(addr_count), 64'd0);
        bus_rdata = 64'h22;
        tick;
        chk("re_lw1",  64'(line_write), 64'd1);
        chk("re_off1", 64'(addr_count), 64'd8);
        bus_err = 1'b1; bus_rdata = 64'h33;
        tick;
        chk("re_berr",  64'(bus_error),          64'd1);
        chk("re_nolw",  64'(line_write),         64'd0);
        chk("re_notr",  64'(trans_rdy),          64'd0);
        chk("re_norf",  64'(cache_entry_refill), 64'd0);
        chk("re_cnt",   64'(addr_count),         64'd0);
        chk("re_reqlo", 64'(bus_req),            64'd0);
        chk("re_data",  line_data,               64'h22);
        bus_ack = 1'b0; bus_err = 1'b0;
        tick;
        chk("re_pulse", 64'(bus_error), 64'd0);
        tick;

        // watchdog: no response at all
        read_req = 1'b1; pa = 64'h3000; L1_size = 4'b1000;
        tick;
        chk("wd_req", 64'(bus_req), 64'd1);
        read_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick;
            chk("wd_quiet", 64'(bus_error), 64'd0);
            chk("wd_wreq",  64'(bus_req),   64'd1);
        end
        tick;
        chk("wd_fire",  64'(bus_error), 64'd1);
        chk("wd_reqlo", 64'(bus_req),   64'd0);
        chk("wd_notr",  64'(trans_rdy), 64'd0);
        tick;
        chk("wd_pulse", 64'(bus_error), 64'd0);
        tick;

        // reset during beat 1 of a refill, then a normal read
        read_line_req = 1'b1; pa = 64'h5000;
        tick;
        read_line_req = 1'b0; bus_ack = 1'b1; bus_rdata = 64'h77;
        tick;
        chk("rr_lw",   64'(line_write), 64'd1);
        chk("rr_addr", bus_addr,        64'h5008);
        bus_ack = 1'b0; rst = 1'b0;
        tick;
        chk("rr_req",  64'(bus_req),    64'd0);
        chk("rr_badr", bus_addr,        64'd0);
        chk("rr_data", line_data,       64'd0);
        chk("rr_lw0",  64'(line_write), 64'd0);
        chk("rr_size", 64'(bus_size),   64'd0);
        rst = 1'b1;
        tick;
        read_req = 1'b1; pa = 64'h6008; L1_size = 4'b1000;
        tick;
        chk("rr2_req",  64'(bus_req), 64'd1);
        chk("rr2_addr", bus_addr,     64'h6008);
        read_req = 1'b0; bus_ack = 1'b1; bus_rdata = 64'h55;
        tick;
        chk("rr2_trdy", 64'(trans_rdy), 64'd1);
        chk("rr2_data", line_data,      64'h55);
        bus_ack = 1'b0;
        tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
